// File: rtl/lru_set_tracker.sv
// True-LRU replacement state for SETS independent sets of WAYS ways.
// Each set holds an age permutation (0 = MRU, WAYS-1 = LRU); the victim read is combinational.
module lru_set_tracker #(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_en,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             inv_en,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic [SET_W-1:0] query_set,
    input  logic [WAYS-1:0]  lock_mask,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid
);

    localparam logic [SET_W:0]   SET_LIMIT = (SET_W + 1)'(SETS);
    localparam logic [WAY_W-1:0] AGE_LRU   = WAY_W'(WAYS - 1);
    localparam logic [WAY_W-1:0] AGE_ONE   = WAY_W'(1);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];
    logic             touch_ok;
    logic             inv_ok;
    logic             query_ok;
    logic [WAY_W-1:0] touch_old;
    logic [WAY_W-1:0] inv_old;
    logic [WAY_W-1:0] best_age;
    logic             found;

    // A touch wins over an invalidate aimed at the same set; the caller retries the invalidate.
    assign touch_ok = touch_en && ({1'b0, touch_set} < SET_LIMIT);
    assign inv_ok   = inv_en && ({1'b0, inv_set} < SET_LIMIT)
                      && !(touch_ok && (inv_set == touch_set));
    assign query_ok = ({1'b0, query_set} < SET_LIMIT);

    always_comb begin
        age_d     = age_q;
        touch_old = '0;
        inv_old   = '0;
        if (touch_ok) begin
            touch_old = age_q[touch_set][touch_way];
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_d[touch_set][w] = '0;
                end else if (age_q[touch_set][w] < touch_old) begin
                    age_d[touch_set][w] = age_q[touch_set][w] + AGE_ONE;
                end
            end
        end
        if (inv_ok) begin
            inv_old = age_q[inv_set][inv_way];
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == inv_way) begin
                    age_d[inv_set][w] = AGE_LRU;
                end else if (age_q[inv_set][w] > inv_old) begin
                    age_d[inv_set][w] = age_q[inv_set][w] - AGE_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    // Ages are a permutation, so the strict '>' never has to break a tie.
    always_comb begin
        found        = 1'b0;
        best_age     = '0;
        victim_way   = '0;
        if (query_ok) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!lock_mask[w] && (!found || (age_q[query_set][w] > best_age))) begin
                    found      = 1'b1;
                    best_age   = age_q[query_set][w];
                    victim_way = WAY_W'(w);
                end
            end
        end
        victim_valid = found;
    end

endmodule

// File: tb/tb_lru_set_tracker.sv
// Bench for lru_set_tracker: a 4x16 instance for directed cases and an 8x12 instance for random traffic.
// The model keeps each set as a recency list (MRU first) and derives victims from it.
module tb_lru_set_tracker;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_on = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance A: WAYS=4, SETS=16
    logic       touch_en_a, inv_en_a;
    logic [3:0] touch_set_a, inv_set_a, query_set_a;
    logic [1:0] touch_way_a, inv_way_a, victim_way_a;
    logic [3:0] lock_mask_a;
    logic       victim_valid_a;

    // Instance B: WAYS=8, SETS=12
    logic       touch_en_b, inv_en_b;
    logic [3:0] touch_set_b, inv_set_b, query_set_b;
    logic [2:0] touch_way_b, inv_way_b, victim_way_b;
    logic [7:0] lock_mask_b;
    logic       victim_valid_b;

    lru_set_tracker #(.WAYS(4), .SETS(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .touch_en(touch_en_a), .touch_set(touch_set_a), .touch_way(touch_way_a),
        .inv_en(inv_en_a), .inv_set(inv_set_a), .inv_way(inv_way_a),
        .query_set(query_set_a), .lock_mask(lock_mask_a),
        .victim_way(victim_way_a), .victim_valid(victim_valid_a)
    );

    lru_set_tracker #(.WAYS(8), .SETS(12)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .touch_en(touch_en_b), .touch_set(touch_set_b), .touch_way(touch_way_b),
        .inv_en(inv_en_b), .inv_set(inv_set_b), .inv_way(inv_way_b),
        .query_set(query_set_b), .lock_mask(lock_mask_b),
        .victim_way(victim_way_b), .victim_valid(victim_valid_b)
    );

    // ---------------- model: mdl[d][s][k] = way at recency rank k ----------------
    int mdl [2][16][8];

    function automatic void mdl_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 16; s++)
                for (int k = 0; k < 8; k++)
                    mdl[d][s][k] = k;
    endfunction

    function automatic void mdl_move(int d, int s, int w, int nw, bit to_front);
        int tmp[$];
        for (int k = 0; k < nw; k++)
            if (mdl[d][s][k] != w) tmp.push_back(mdl[d][s][k]);
        if (to_front) tmp.push_front(w);
        else tmp.push_back(w);
        for (int k = 0; k < nw; k++) mdl[d][s][k] = tmp[k];
    endfunction

    // Returns the least recently used unlocked way, or -1 when none is selectable.
    function automatic int mdl_victim(int d, int s, int nw, int ns, logic [7:0] mask);
        if (s >= ns) return -1;
        for (int k = nw - 1; k >= 0; k--)
            if (!mask[mdl[d][s][k]]) return mdl[d][s][k];
        return -1;
    endfunction

    function automatic void mdl_apply(int d, int nw, int ns, logic te, int ts, int tw,
                                      logic ie, int is, int iw);
        bit t_ok, i_ok;
        t_ok = te && (ts < ns);
        i_ok = ie && (is < ns) && !(t_ok && (is == ts));
        if (t_ok) mdl_move(d, ts, tw, nw, 1'b1);
        if (i_ok) mdl_move(d, is, iw, nw, 1'b0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_reset();
        end else begin
            mdl_apply(0, 4, 16, touch_en_a, int'(touch_set_a), int'(touch_way_a),
                      inv_en_a, int'(inv_set_a), int'(inv_way_a));
            mdl_apply(1, 8, 12, touch_en_b, int'(touch_set_b), int'(touch_way_b),
                      inv_en_b, int'(inv_set_b), int'(inv_way_b));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int va, vb;
            va = mdl_victim(0, int'(query_set_a), 4, 16, {4'b0, lock_mask_a});
            vb = mdl_victim(1, int'(query_set_b), 8, 12, lock_mask_b);
            chk("mon_a_valid", int'(victim_valid_a), (va >= 0) ? 1 : 0);
            chk("mon_a_way", int'(victim_way_a), (va >= 0) ? va : 0);
            chk("mon_b_valid", int'(victim_valid_b), (vb >= 0) ? 1 : 0);
            chk("mon_b_way", int'(victim_way_b), (vb >= 0) ? vb : 0);
        end
    end

    // ---------------- driver tasks (entered and left 1 time unit after a rising edge) ----------------
    task automatic a_op(logic te, int ts, int tw, logic ie, int is, int iw);
        touch_en_a = te; touch_set_a = 4'(ts); touch_way_a = 2'(tw);
        inv_en_a = ie; inv_set_a = 4'(is); inv_way_a = 2'(iw);
        @(posedge clk); #1;
        touch_en_a = 1'b0; inv_en_a = 1'b0;
    endtask

    task automatic a_expect(string name, int qs, logic [3:0] mask, int exp_valid, int exp_way);
        query_set_a = 4'(qs); lock_mask_a = mask;
        @(negedge clk);
        chk({name, "_valid"}, int'(victim_valid_a), exp_valid);
        chk({name, "_way"}, int'(victim_way_a), exp_way);
        @(posedge clk); #1;
    endtask

    task automatic b_expect(string name, int qs, logic [7:0] mask, int exp_valid, int exp_way);
        query_set_b = 4'(qs); lock_mask_b = mask;
        @(negedge clk);
        chk({name, "_valid"}, int'(victim_valid_b), exp_valid);
        chk({name, "_way"}, int'(victim_way_b), exp_way);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        touch_en_a = 0; touch_set_a = 0; touch_way_a = 0;
        inv_en_a = 0; inv_set_a = 0; inv_way_a = 0;
        query_set_a = 0; lock_mask_a = 0;
        touch_en_b = 0; touch_set_b = 0; touch_way_b = 0;
        inv_en_b = 0; inv_set_b = 0; inv_way_b = 0;
        query_set_b = 0; lock_mask_b = 0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_on = 1'b1;

        // reset state
        a_expect("rst_s5", 5, 4'b0000, 1, 3);
        a_expect("rst_s0", 0, 4'b0000, 1, 3);
        a_expect("rst_s15", 15, 4'b0000, 1, 3);
        b_expect("rst_b_s0", 0, 8'h00, 1, 7);
        b_expect("rst_b_oor", 13, 8'h00, 0, 0);

        // touch sequence in set 2
        a_op(1, 2, 3, 0, 0, 0);
        a_op(1, 2, 2, 0, 0, 0);
        a_op(1, 2, 1, 0, 0, 0);
        a_op(1, 2, 0, 0, 0, 0);
        a_expect("touch_seq", 2, 4'b0000, 1, 3);
        a_op(1, 2, 3, 0, 0, 0);
        a_expect("touch_again", 2, 4'b0000, 1, 2);
        a_expect("touch_other_set", 7, 4'b0000, 1, 3);
        chk("pin_model_s2", mdl_victim(0, 2, 4, 16, 8'h00), 2);
        a_op(1, 2, 3, 0, 0, 0);
        a_expect("touch_mru_noop", 2, 4'b0000, 1, 2);

        // invalidate in set 4: ways 1..3 take ages 0..2, way 0 becomes LRU
        a_op(0, 0, 0, 1, 4, 0);
        a_expect("inv_victim", 4, 4'b0000, 1, 0);
        a_expect("inv_lock0", 4, 4'b0001, 1, 3);
        a_expect("inv_lock03", 4, 4'b1001, 1, 2);
        a_expect("inv_lock023", 4, 4'b1101, 1, 1);
        chk("pin_model_s4", mdl_victim(0, 4, 4, 16, 8'h01), 3);
        a_op(0, 0, 0, 1, 4, 0);
        a_expect("inv_lru_noop", 4, 4'b0001, 1, 3);
        a_op(1, 4, 0, 0, 0, 0);
        a_expect("inv_then_touch", 4, 4'b0000, 1, 3);

        // lock mask
        a_expect("lock_1000", 6, 4'b1000, 1, 2);
        a_expect("lock_1111", 6, 4'b1111, 0, 0);
        a_expect("lock_0111", 6, 4'b0111, 1, 3);

        // simultaneous operations
        a_op(1, 1, 3, 1, 1, 0);
        a_expect("same_set_touch_wins", 1, 4'b0000, 1, 2);
        a_op(1, 1, 3, 1, 9, 0);
        a_expect("diff_set_inv", 9, 4'b0000, 1, 0);
        a_expect("diff_set_touch", 1, 4'b0000, 1, 2);
        chk("pin_model_s9", mdl_victim(0, 9, 4, 16, 8'h00), 0);

        // out-of-range operations on B leave state untouched
        touch_en_b = 1; touch_set_b = 4'd12; touch_way_b = 3'd7;
        inv_en_b = 1; inv_set_b = 4'd15; inv_way_b = 3'd0;
        @(posedge clk); #1;
        touch_en_b = 0; inv_en_b = 0;
        b_expect("oor_s0", 0, 8'h00, 1, 7);
        b_expect("oor_s11", 11, 8'h80, 1, 6);
        b_expect("oor_q12", 12, 8'h00, 0, 0);
        b_expect("oor_q15", 15, 8'h00, 0, 0);

        // random traffic on B, with a mid-stream asynchronous reset
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
                touch_en_b = 0; inv_en_b = 0;
                for (int s = 0; s < 12; s++) b_expect("midrst_lru", s, 8'h00, 1, 7);
                b_expect("midrst_rank", 3, 8'hc0, 1, 5);
                a_expect("midrst_a", 2, 4'b0000, 1, 3);
            end
            touch_en_b  = ($urandom_range(0, 3) != 0);
            touch_set_b = 4'($urandom_range(0, 15));
            touch_way_b = 3'($urandom_range(0, 7));
            inv_en_b    = ($urandom_range(0, 2) == 0);
            inv_set_b   = ($urandom_range(0, 7) == 0) ? touch_set_b : 4'($urandom_range(0, 15));
            inv_way_b   = 3'($urandom_range(0, 7));
            query_set_b = ($urandom_range(0, 1) == 0) ? touch_set_b : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: lock_mask_b = 8'h00;
                1: lock_mask_b = 8'hff;
                default: lock_mask_b = 8'($urandom_range(0, 255));
            endcase
            @(posedge clk); #1;
        end
        touch_en_b = 0; inv_en_b = 0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lru_set_tracker.md
# lru_set_tracker

Multi-set, multi-way true-LRU replacement tracker for set-associative caches and TLBs. It generalises the single-way age counter to `SETS` independent sets of `WAYS` ways, holding a strict age permutation per set. It supports touch (make MRU), invalidate (make LRU) and a per-query lock mask. It sits beside the tag array: the lookup pipeline issues touches and invalidates, and the refill path reads the victim combinationally.

## Interface
- `WAYS`, default 4: ways per set; power of two, at least 2.
- `SETS`, default 16: number of sets; at least 1, need not be a power of two.
- `WAY_W`, derived: `$clog2(WAYS)`; width of way indices and ages.
- `SET_W`, derived: `max(1, $clog2(SETS))`; width of set indices.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `touch_en`  in  1  apply a touch this cycle.
- `touch_set`  in  SET_W  set being touched.
- `touch_way`  in  WAY_W  way being made MRU.
- `inv_en`  in  1  apply an invalidate this cycle.
- `inv_set`  in  SET_W  set being invalidated.
- `inv_way`  in  WAY_W  way being made LRU.
- `query_set`  in  SET_W  set whose victim is requested; combinational read.
- `lock_mask`  in  WAYS  bit w=1 excludes way w from victim selection.
- `victim_way`  out  WAY_W  oldest unlocked way of `query_set`.
- `victim_valid`  out  1  1 when at least one way is selectable.

## Operation
- **State:** one age per way per set, `WAY_W` bits each. Age 0 is MRU; age WAYS-1 is LRU.
- **Invariant:** the ages within a set always form a permutation of 0..WAYS-1.
- **Reset:** while `rst_n`=0, every set holds age[w]=w.
  - Immediately after reset, with `lock_mask`=0, `victim_way`=WAYS-1 and `victim_valid`=1 for any legal `query_set`.
- **Touch** (set s, way w, old age a):
  - Every way in s with age < a increments.
  - age[w] becomes 0.
  - Other ways are unchanged.
  - Touching the current MRU (a=0) changes nothing.
- **Invalidate** (set s, way w, old age a):
  - Every way in s with age > a decrements.
  - age[w] becomes WAYS-1.
  - Invalidating the current LRU changes nothing.
- **Both enables, different sets:** both operations apply in the same cycle.
- **Both enables, same set (any way):** the touch applies and the invalidate is dropped. The caller must retry it.
- **Out-of-range set index** (index ≥ SETS):
  - Touch and invalidate are ignored.
  - A query returns `victim_valid`=0 and `victim_way`=0.
- **Victim selection:** among ways with `lock_mask[w]`=0, pick the way with the highest age. Ties cannot occur.
  - If all ways are locked: `victim_valid`=0, `victim_way`=0.
- **Update width rule:** all age arithmetic stays within WAY_W bits. No wrap can occur while the invariant holds.

## Timing
- Touch and invalidate are synchronous: they take effect at the rising edge where their enable is sampled high.
- The query path is purely combinational from `query_set`, `lock_mask` and registered state.
  - There is no write-to-read bypass: an update in cycle n is visible to a query in cycle n+1.
- Back-to-back touches or invalidates to the same set on consecutive cycles are supported with full throughput. Each operation sees the result of the previous one.
- Asserting `rst_n` mid-operation:
  - All sets return to age[w]=w immediately, independent of `clk`.
  - Any update in flight is lost.
  - The outputs follow combinationally from the reset state.
- No output is registered.
  - Reset values: `victim_way`=WAYS-1 and `victim_valid`=1 for a legal `query_set` with `lock_mask`=0.
  - Otherwise the reset values follow the selection rules above.

## Test plan
All scenarios use WAYS=4, SETS=16 unless stated.
- **Reset:** release `rst_n`, set `query_set`=5, `lock_mask`=0 → `victim_way`=3, `victim_valid`=1. Repeat for sets 0 and 15.
- **Touch sequence:** in set 2, touch ways 3, 2, 1, 0 on consecutive cycles → `victim_way`=3. Then touch way 3 → `victim_way`=2. Set 7 still reports 3.
- **Invalidate:** in set 4 after reset, invalidate way 0 → `victim_way`=0, and ages of ways 1–3 become 0–2. Then touch way 0 → `victim_way`=3.
- **Lock mask:** after reset, set `lock_mask`=4'b1000 → `victim_way`=2. `lock_mask`=4'b1111 → `victim_valid`=0, `victim_way`=0.
- **Simultaneous operations:**
  - Touch set 1 way 3 together with invalidate set 1 way 0 → only the touch applies; `victim_way`=2.
  - Touch set 1 way 3 together with invalidate set 9 way 0 → both apply; set 9 `victim_way`=0.
- **Random check and reset mid-operation** (WAYS=8, SETS=12):
  - Run 10k random touch/invalidate operations against a reference model. Assert the permutation invariant every cycle.
  - Indices 12–15 must leave state unchanged, and queries to them give `victim_valid`=0.
  - Pulse `rst_n` low mid-stream → all sets return to age[w]=w.
